valu_result_queue: RTL and testbench
====================================

Name: valu_result_queue

Overview:
- Receive-side endpoint for the vector ALU result stream.
- Captures each cycle's valid result (data plus destination VRF address) into a FIFO and drains it to the vector register file write port with a valid/ready handshake.
- Provides stall back-pressure to the issue stage, a flush/drain sequence, and sticky error reporting.
- Sits between the VALU output and the VRF write port.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- DATA_W, 32, result width.
- ADDR_W, 8, VRF address width.
- DEAD_MARK, 32'hDEAD_DEAD, invalid-result marker driven by the VALU.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  reset, synchronous, active-low.
- in_valid  input  1  VALU valid_out; one result per cycle while high.
- in_data  input  DATA_W  VALU out_res.
- in_addr  input  ADDR_W  VALU vrfo_addr, the destination VRF address.
- stall  output  1  to issue stage: hold VALU issue (count >= DEPTH-1).
- vrf_we  output  1  write-valid to VRF.
- vrf_addr  output  ADDR_W  write address, from FIFO head.
- vrf_wdata  output  DATA_W  write data, from FIFO head.
- vrf_ready  input  1  VRF accepts the write this cycle.
- flush_req  input  1  request drain-and-hold.
- flush_done  output  1  one-cycle pulse when the drain completes.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Reset, sampled at the clk edge with nrst=0:
  - pointers and count cleared to 0; FSM to IDLE.
  - vrf_we=0, stall=0, flush_done=0, overflow=0.
  - vrf_addr and vrf_wdata are 0 while empty.
  - Reset mid-write discards all queued entries; there is no partial write-back.
- Push: in_valid=1 at an edge and FIFO not full (after any same-cycle pop) -> {in_addr,in_data} written at the tail; tail advances and wraps at DEPTH.
  - One push per cycle. A held VALU output produces one entry per cycle; the issue stage must deassert valu_en.
- Pop: vrf_we=1 and vrf_ready=1 at an edge -> head advances and wraps at DEPTH.
- Show-ahead head: vrf_we, vrf_addr and vrf_wdata are combinational from head and state.
  - vrf_we = (count!=0) && state!=HOLD.
  - Latency: data pushed at edge N appears with vrf_we=1 in the cycle after edge N when the FIFO was empty.
- vrf_we stays high and vrf_addr/vrf_wdata stay stable until vrf_ready; no retraction.
- Simultaneous push and pop:
  - count unchanged.
  - Allowed when full: the pop frees the slot, so the push succeeds with no overflow.
  - Allowed when empty only if bypass is not used; the entry is pushed, not popped that cycle.
- Full: push with count==DEPTH and no pop -> data dropped, overflow set until reset.
- stall = (count >= DEPTH-1), registered from next-count. This gives one cycle of slack for the combinational VALU.
- FSM:
  - IDLE: normal push/pop. flush_req=1 -> DRAIN.
  - DRAIN: pushes still accepted; stall forced to 1. count==0 with no push pending -> DONE.
  - DONE: flush_done=1 for exactly one cycle -> HOLD.
  - HOLD: stall=1, vrf_we=0, pushes ignored. flush_req=0 -> IDLE.
- flush_req asserted while the FIFO is already empty -> DRAIN lasts one cycle, DONE the next.

Optional Feature:
- Macro VRQ_DROP_DEAD_EN.
- Defined: a push whose in_data==DEAD_MARK is silently discarded even with in_valid=1. A 16-bit saturating dead_cnt register (internal, visible in hierarchy) increments on each discard.
- Undefined: DEAD_MARK is treated as ordinary data and queued; the VALU valid_out is trusted.

Test Plan:
- Reset then single result: in_valid=1, in_data=32'h0000_0007, in_addr=8'h10 for one cycle; vrf_ready=1 -> next cycle vrf_we=1, vrf_addr=8'h10, vrf_wdata=7; the cycle after, vrf_we=0 and count=0.
- Back-pressure: vrf_ready=0, push 8 results 1..8 at addr 0..7 -> stall=1 once count reaches 7; count=8. A 9th push sets overflow=1. Raise vrf_ready -> writes 1..8 in order, addr 0..7; overflow stays 1.
- Full with simultaneous push/pop: count=8, vrf_ready=1, in_valid=1, data 9 -> count stays 8, overflow stays 0, data 9 is written last.
- Flush: 3 queued, flush_req=1, vrf_ready=1 -> 3 writes; flush_done pulses once; HOLD blocks a push of data 5 (count stays 0); flush_req=0 -> IDLE.
- Reset mid-drain: 4 queued, vrf_ready=0, nrst=0 for one cycle -> count=0, vrf_we=0, overflow=0, state IDLE.
- VRQ_DROP_DEAD_EN defined: push 32'hDEAD_DEAD then 32'h1 -> only 32'h1 is written, dead_cnt=1. Undefined: both are written, in order.

Source files
------------

// File: rtl/valu_result_queue.sv
// valu_result_queue: receive-side endpoint for the vector ALU result stream.
// Each valid VALU result ({in_addr, in_data}) is pushed into a DEPTH-entry
// FIFO. The FIFO drains to the VRF write port through a show-ahead
// valid/ready handshake.
//
// Ports:
//   clk, nrst            clock; synchronous active-low reset
//   in_valid/in_data/in_addr   VALU result stream (one push per cycle)
//   stall                hold VALU issue (registered occupancy >= DEPTH-1,
//                        forced high during the flush sequence)
//   vrf_we/vrf_addr/vrf_wdata  FIFO head, combinational (show-ahead)
//   vrf_ready            VRF accepts the head this cycle
//   flush_req            request drain-and-hold
//   flush_done           one-cycle pulse when the drain completes
//   count                current occupancy
//   overflow             sticky: a push was attempted while full
//
// Optional feature macro: VRQ_DROP_DEAD_EN
//   When defined, a push whose in_data equals DEAD_MARK is discarded and the
//   internal 16-bit saturating dead_cnt counts the discards.
module valu_result_queue #(
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [DATA_W-1:0] DEAD_MARK = 32'hDEAD_DEAD
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   stall,
    output logic                   vrf_we,
    output logic [ADDR_W-1:0]      vrf_addr,
    output logic [DATA_W-1:0]      vrf_wdata,
    input  logic                   vrf_ready,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE, HOLD} state_t;

    state_t                   state, state_next;
    logic [PW-1:0]            head, tail;
    logic [CW-1:0]            count_next;
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic                     stall_q;
    logic                     pop, push_req, push, dead;

`ifdef VRQ_DROP_DEAD_EN
    logic [15:0] dead_cnt;

    always_comb begin
        dead = (in_data == DEAD_MARK);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            dead_cnt <= '0;
        end else if (in_valid && (state != HOLD) && dead && (dead_cnt != '1)) begin
            dead_cnt <= dead_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        dead = 1'b0;
    end
`endif

    // Datapath: show-ahead head, push/pop qualification, next occupancy.
    always_comb begin
        vrf_we                = (count != '0) && (state != HOLD);
        {vrf_addr, vrf_wdata} = (count != '0) ? mem[head] : '0;
        pop                   = vrf_we && vrf_ready;
        push_req              = in_valid && (state != HOLD) && !dead;
        // A same-cycle pop frees the slot, so a full FIFO still accepts.
        push                  = push_req && ((count != FULL_CNT) || pop);
        count_next            = count + CW'(push) - CW'(pop);
    end

    // Flush sequence FSM.
    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        case (state)
            IDLE:  if (flush_req) state_next = DRAIN;
            DRAIN: if ((count == '0) && !push) state_next = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_next = HOLD;
            end
            HOLD:  if (!flush_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        stall = stall_q || (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            stall_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            stall_q <= (count_next >= STALL_CNT);
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible through head/count.
    always_ff @(posedge clk) begin
        if (nrst && push) mem[tail] <= {in_addr, in_data};
    end

endmodule

// File: tb/tb_valu_result_queue.sv
module tb_valu_result_queue;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam logic [31:0] DEAD   = 32'hDEAD_DEAD;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              stall;
    logic              vrf_we;
    logic [ADDR_W-1:0] vrf_addr;
    logic [DATA_W-1:0] vrf_wdata;
    logic              vrf_ready;
    logic              flush_req;
    logic              flush_done;
    logic [3:0]        count;
    logic              overflow;

    valu_result_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEAD_MARK(DEAD)
    ) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
        .in_addr(in_addr), .stall(stall), .vrf_we(vrf_we), .vrf_addr(vrf_addr),
        .vrf_wdata(vrf_wdata), .vrf_ready(vrf_ready), .flush_req(flush_req),
        .flush_done(flush_done), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {addr,data} entries plus flush phase.
    // Phase: 0 normal, 1 draining, 2 done pulse, 3 holding.
    logic [39:0] m_q[$];
    int          m_state = 0;
    bit          m_ovf = 1'b0;
    int          m_dead = 0;

    always @(posedge clk) begin
        int  sz;
        bit  we, pop, is_dead, want, acc;
        if (!nrst) begin
            m_q.delete();
            m_state = 0;
            m_ovf   = 1'b0;
            m_dead  = 0;
        end else begin
            sz  = m_q.size();
            we  = (sz != 0) && (m_state != 3);
            pop = we && vrf_ready;
`ifdef VRQ_DROP_DEAD_EN
            is_dead = (in_data == DEAD);
`else
            is_dead = 1'b0;
`endif
            if (in_valid && m_state != 3 && is_dead && m_dead < 65535) m_dead++;
            want = in_valid && (m_state != 3) && !is_dead;
            acc  = want && (sz < DEPTH || pop);
            if (want && !acc) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back({in_addr, in_data});
            case (m_state)
                0: if (flush_req) m_state = 1;
                1: if (sz == 0 && !acc) m_state = 2;
                2: m_state = 3;
                default: if (!flush_req) m_state = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [39:0] head;
        if (chk_en) begin
            head = (m_q.size() != 0) ? m_q[0] : 40'h0;
            chk("count", count, m_q.size());
            chk("vrf_we", vrf_we, (m_q.size() != 0) && (m_state != 3));
            chk("vrf_addr", vrf_addr, head[39:32]);
            chk("vrf_wdata", vrf_wdata, head[31:0]);
            chk("overflow", overflow, m_ovf);
            chk("flush_done", flush_done, m_state == 2);
            if (m_state != 2)
                chk("stall", stall, (m_q.size() >= DEPTH - 1) || (m_state != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        in_valid = 1'b0;
        flush_req = 1'b0;
        tick();
        nrst = 1'b1;
    endtask

    task automatic push1(input logic [31:0] d, input logic [7:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int writes, pulses;
        nrst = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
        vrf_ready = 1'b0; flush_req = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_we", vrf_we, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_addr", vrf_addr, 0);

        // Single result
        vrf_ready = 1'b1;
        push1(32'h7, 8'h10);
        chk("single_we", vrf_we, 1);
        chk("single_addr", vrf_addr, 8'h10);
        chk("single_data", vrf_wdata, 32'h7);
        tick();
        chk("single_we_after", vrf_we, 0);
        chk("single_cnt_after", count, 0);

        // Back-pressure and overflow
        vrf_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push1(32'(i), 8'(i - 1));
            if (i == 6) chk("bp_stall6", stall, 0);
            if (i == 7) chk("bp_stall7", stall, 1);
        end
        chk("bp_count8", count, 8);
        chk("model_count8", m_q.size(), 8);
        chk("bp_ovf0", overflow, 0);
        push1(32'd99, 8'hFF);
        chk("bp_ovf1", overflow, 1);
        chk("bp_count_full", count, 8);
        vrf_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("bp_drain_we", vrf_we, 1);
            chk("bp_drain_data", vrf_wdata, 32'(i));
            chk("bp_drain_addr", vrf_addr, 8'(i - 1));
            tick();
        end
        chk("bp_empty", count, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // Full with simultaneous push/pop
        do_reset();
        vrf_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push1(32'(i), 8'(i - 1));
        vrf_ready = 1'b1;
        push1(32'd9, 8'h08);
        chk("fsp_count", count, 8);
        chk("fsp_ovf", overflow, 0);
        for (int k = 0; k < 8; k++) begin
            chk("fsp_data", vrf_wdata, (k < 7) ? 32'(k + 2) : 32'd9);
            tick();
        end
        chk("fsp_empty", count, 0);

        // Flush
        vrf_ready = 1'b0;
        for (int i = 0; i < 3; i++) push1(32'(11 + i), 8'(20 + i));
        flush_req = 1'b1;
        vrf_ready = 1'b1;
        writes = 0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            writes += int'(vrf_we);
            pulses += int'(flush_done);
            tick();
        end
        chk("flush_writes", writes, 3);
        chk("flush_pulses", pulses, 1);
        chk("hold_stall", stall, 1);
        push1(32'd5, 8'h05);
        chk("hold_count", count, 0);
        chk("hold_we", vrf_we, 0);
        flush_req = 1'b0;
        tick();
        chk("idle_stall", stall, 0);

        // Reset mid-drain
        vrf_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(32'(40 + i), 8'(i));
        chk("mid_count4", count, 4);
        do_reset();
        chk("mid_count", count, 0);
        chk("mid_we", vrf_we, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_stall", stall, 0);

        // Dead-marker handling
        push1(DEAD, 8'h01);
        push1(32'h1, 8'h02);
`ifdef VRQ_DROP_DEAD_EN
        chk("dead_count", count, 1);
        chk("dead_data", vrf_wdata, 32'h1);
        chk("dead_cnt", dut.dead_cnt, 1);
`else
        chk("dead_count", count, 2);
        chk("dead_first", vrf_wdata, DEAD);
        vrf_ready = 1'b1;
        tick();
        chk("dead_second", vrf_wdata, 32'h1);
`endif
        vrf_ready = 1'b1;
        tick();
        tick();
        chk("dead_empty", count, 0);

        // Randomized phase, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            nrst      = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = ($urandom_range(0, 7) == 0) ? DEAD : $urandom;
            in_addr   = 8'($urandom);
            vrf_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 31) == 0) flush_req = ~flush_req;
            tick();
        end
        in_valid = 1'b0;
        flush_req = 1'b0;
        tick();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
